// File: rtl/vga_timing_pkg.sv
// Shared VGA raster timing constants (640x480 @ 60 Hz defaults) and helpers.
// Imported by the sync generator, its interface and downstream drawing blocks.
// Contents: timing defaults, derived totals, sync windows, coordinate width.
package vga_timing_pkg;

    // Coordinate width carried on x/y; both totals must fit in it.
    localparam int COORD_W   = 10;
    localparam int MAX_TOTAL = 1 << COORD_W;

    // Default timing: 640x480 @ 60 Hz from a 50 MHz clock.
    localparam int DEF_H_DISPLAY = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_DISPLAY = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;
    localparam int DEF_TICK_DIV  = 2;

    localparam int DEF_H_TOTAL = DEF_H_DISPLAY + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int DEF_V_TOTAL = DEF_V_DISPLAY + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    // Inclusive sync windows for the default timing.
    localparam int DEF_HSYNC_START = DEF_H_DISPLAY + DEF_H_FRONT;
    localparam int DEF_HSYNC_END   = DEF_HSYNC_START + DEF_H_SYNC - 1;
    localparam int DEF_VSYNC_START = DEF_V_DISPLAY + DEF_V_FRONT;
    localparam int DEF_VSYNC_END   = DEF_VSYNC_START + DEF_V_SYNC - 1;

    // Visible area seen by the drawing blocks.
    localparam int DISPLAY_WIDTH  = DEF_H_DISPLAY;
    localparam int DISPLAY_HEIGHT = DEF_V_DISPLAY;

    // Inclusive range test used for the sync windows.
    function automatic logic in_window(input int val, input int lo, input int hi);
        return (val >= lo) && (val <= hi);
    endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Raster timing bundle from vga_sync_gen to the drawing blocks.
// master: driven by the sync generator; slave: consumed by drawing blocks.
// Signals: x/y pixel position, p_tick, hsync/vsync (active low), video_on, frame_end.
interface vga_sync_gen_if;
    import vga_timing_pkg::*;

    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               p_tick;
    logic               hsync;
    logic               vsync;
    logic               video_on;
    logic               frame_end;

    modport master (
        output x, y, p_tick, hsync, vsync, video_on, frame_end
    );

    modport slave (
        input  x, y, p_tick, hsync, vsync, video_on, frame_end
    );

endinterface

// File: rtl/vga_sync_gen_counter.sv
// Modulo-MOD counter with enable; wrap flags the enabled edge that returns to 0.
// Latency: count updates on the clk edge after en; wrap is combinational from count/en.
// No backpressure. Ports: clk, reset (sync, active high), en, count, wrap.
module mod_counter #(
    parameter int MOD = 2,
    parameter int W   = (MOD > 1) ? $clog2(MOD) : 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         wrap
);

    if (MOD < 1) begin : g_bad_mod
        $error("mod_counter: MOD must be >= 1");
    end
    if ((64'd1 << W) < 64'(MOD)) begin : g_bad_width
        $error("mod_counter: W too narrow for MOD");
    end

    // With MOD=1 count stays 0 and wrap follows en every cycle.
    assign wrap = en && (count == W'(MOD - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (en) begin
            count <= wrap ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel tick, x/y counters, hsync/vsync, video_on, frame_end.
// Latency: sync/video_on registered together with x/y, so they always describe the current x/y.
// No backpressure; free-running. Ports: clk, reset (sync, active high), vga (master modport).
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int H_DISPLAY = DEF_H_DISPLAY,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_DISPLAY = DEF_V_DISPLAY,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK,
    parameter int TICK_DIV  = DEF_TICK_DIV
) (
    input  logic           clk,
    input  logic           reset,
    vga_sync_gen_if.master vga
);

    localparam int H_TOTAL     = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL     = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int HSYNC_START = H_DISPLAY + H_FRONT;
    localparam int HSYNC_END   = HSYNC_START + H_SYNC - 1;
    localparam int VSYNC_START = V_DISPLAY + V_FRONT;
    localparam int VSYNC_END   = VSYNC_START + V_SYNC - 1;
    localparam int DIV_W       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_total
        $error("vga_sync_gen: H_TOTAL and V_TOTAL must be <= 1024");
    end
    if (TICK_DIV < 1) begin : g_bad_div
        $error("vga_sync_gen: TICK_DIV must be >= 1");
    end

    logic [DIV_W-1:0]   div_count;
    logic [COORD_W-1:0] h_count;
    logic [COORD_W-1:0] v_count;
    logic               p_tick;
    logic               h_wrap;
    logic               v_wrap;
    logic [COORD_W-1:0] h_next;
    logic [COORD_W-1:0] v_next;
    logic               hsync_q;
    logic               vsync_q;
    logic               video_on_q;
    logic               div_count_unused;

    // Pixel tick: the divider's wrap is exactly its terminal-count decode.
    mod_counter #(.MOD(TICK_DIV), .W(DIV_W)) u_div (
        .clk   (clk),
        .reset (reset),
        .en    (1'b1),
        .count (div_count),
        .wrap  (p_tick)
    );

    // Only the divider's wrap decode matters outside it.
    assign div_count_unused = ^div_count;

    mod_counter #(.MOD(H_TOTAL), .W(COORD_W)) u_h (
        .clk   (clk),
        .reset (reset),
        .en    (p_tick),
        .count (h_count),
        .wrap  (h_wrap)
    );

    // v wraps only on the tick that also wraps h, i.e. the last pixel of the frame.
    mod_counter #(.MOD(V_TOTAL), .W(COORD_W)) u_v (
        .clk   (clk),
        .reset (reset),
        .en    (h_wrap),
        .count (v_count),
        .wrap  (v_wrap)
    );

    // Position the counters take on this edge; the sync/video registers decode
    // it so they land on the same edge as x/y with no extra latency.
    always_comb begin
        h_next = h_count;
        v_next = v_count;
        if (h_wrap) begin
            h_next = '0;
        end else if (p_tick) begin
            h_next = h_count + 1'b1;
        end
        if (v_wrap) begin
            v_next = '0;
        end else if (h_wrap) begin
            v_next = v_count + 1'b1;
        end
    end

    // Reset values describe pixel (0,0), which is visible and outside both syncs.
    always_ff @(posedge clk) begin
        if (reset) begin
            hsync_q    <= 1'b1;
            vsync_q    <= 1'b1;
            video_on_q <= 1'b1;
        end else begin
            hsync_q    <= !in_window(int'(h_next), HSYNC_START, HSYNC_END);
            vsync_q    <= !in_window(int'(v_next), VSYNC_START, VSYNC_END);
            video_on_q <= (int'(h_next) < H_DISPLAY) && (int'(v_next) < V_DISPLAY);
        end
    end

    assign vga.x         = h_count;
    assign vga.y         = v_count;
    assign vga.p_tick    = p_tick;
    assign vga.hsync     = hsync_q;
    assign vga.vsync     = vsync_q;
    assign vga.video_on  = video_on_q;
    assign vga.frame_end = v_wrap;

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Generates VGA raster timing: pixel-rate tick, horizontal/vertical pixel counters, active-low hsync/vsync, video_on and an end-of-frame strobe.
- Sits directly upstream of the shape/overlay drawing blocks (rectangle, text, sensor bars). They consume the 10-bit x/y pixel coordinates and video_on.
- Default timing is 640x480 @ 60 Hz from a 50 MHz system clock (25 MHz pixel rate).

Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- TICK_DIV, 2, clk cycles per pixel (must be >=1)

Ports:
- clk  in  1  system clock (50 MHz)
- reset  in  1  synchronous, active-high reset
- x  out  10  current horizontal pixel count, 0..H_TOTAL-1
- y  out  10  current line count, 0..V_TOTAL-1
- p_tick  out  1  one-clk pulse, once per pixel period
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- video_on  out  1  high while (x,y) is in the visible region
- frame_end  out  1  one-clk pulse on the last pixel of the frame

Behaviour:
- Derived constants: H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK (525). Both must be <=1024; elaboration error otherwise.
- Tick divider:
  - Register div counts 0..TICK_DIV-1 every clk, then wraps to 0.
  - p_tick = (div == TICK_DIV-1), decoded from the register.
  - TICK_DIV=1 gives p_tick constantly high.
- Horizontal counter (h, drives x):
  - On a clk edge with p_tick=1: if h == H_TOTAL-1 then h <= 0, else h <= h+1.
  - Holds otherwise.
- Vertical counter (v, drives y):
  - Advances only on an edge where p_tick=1 and h == H_TOTAL-1.
  - Wraps V_TOTAL-1 -> 0 on that same edge; holds otherwise.
- Sync/visibility outputs: registered, and updated on the same edge as h/v so they always describe the current x/y. No extra latency relative to x/y.
  - hsync = 0 iff H_DISPLAY+H_FRONT <= x <= H_DISPLAY+H_FRONT+H_SYNC-1 (656..751), else 1.
  - vsync = 0 iff V_DISPLAY+V_FRONT <= y <= V_DISPLAY+V_FRONT+V_SYNC-1 (490..491), else 1.
  - video_on = (x < H_DISPLAY) && (y < V_DISPLAY).
- frame_end = p_tick && (x == H_TOTAL-1) && (y == V_TOTAL-1). It is one clk wide, once per frame, and coincides with the edge that wraps both counters.
- Reset: on any clk edge with reset=1, the state is forced to div=0, h=0, v=0, hsync=1, vsync=1, video_on=1 (pixel 0,0 is visible).
  - Resulting outputs: p_tick=0 (unless TICK_DIV=1), frame_end=0.
  - Reset mid-line or mid-frame discards all position state; no partial-line completion.
  - The first p_tick after reset release comes TICK_DIV-1 clks later.
- Simultaneous h and v wrap on one edge: both go to 0 together, and frame_end is high in the cycle before that edge.
- Line period is H_TOTAL*TICK_DIV clks; frame period is H_TOTAL*V_TOTAL*TICK_DIV clks (840000 at defaults).

Decomposition:
- Shared package vga_timing_pkg holds:
  - the eight timing defaults;
  - derived H_TOTAL/V_TOTAL;
  - sync-window start/end constants;
  - coordinate width (10).
- Downstream drawing blocks import the same package for DISPLAY_WIDTH/HEIGHT.
- One natural sub-module: mod_counter (parameter MOD, inputs clk/reset/en, outputs count and wrap). It is instantiated three times: divider, h, v.

Test Plan:
- Reset held 3 clks at defaults -> x=0, y=0, hsync=1, vsync=1, video_on=1, p_tick=0, frame_end=0.
- Free-run from reset -> p_tick high every 2nd clk; x reaches 799 after 799 ticks; next tick gives x=0, y=1.
- hsync window -> hsync low exactly while x=656..751: 96 ticks, 192 clks, once per line. video_on falls at x=640 and rises at x=0.
- Full frame -> vsync low only for y=490..491 (1600 ticks). frame_end is a single 1-clk pulse at x=799,y=524, every 840000 clks.
- Reset asserted at x=300,y=200 -> on the next edge x=0, y=0, div=0, hsync=vsync=1. The first p_tick after release occurs 1 clk later.
- TICK_DIV=1, small timing (H 4/1/2/1, V 3/1/1/1) -> p_tick constantly high; x cycles 0..7; hsync low at x=5..6; y advances every 8 clks; frame_end every 48 clks.
